// File: rtl/zeta_pkg.sv
// Shared constants, FSM encoding and layer/length helpers for the zeta ROM reader.
package zeta_pkg;

    localparam int ZETA_W          = 12;
    localparam int KYBER_Q         = 3329;
    localparam int N_ZETAS         = 128;
    localparam int BEATS_PER_XFORM = 896;

    localparam logic MODE_NTT  = 1'b0;
    localparam logic MODE_INTT = 1'b1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_FILL   = 2'd1;
    localparam state_t ST_STREAM = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    // Layer of zeta k is the position of its most significant set bit.
    function automatic logic [2:0] zeta_layer(input logic [6:0] k);
        logic [2:0] lyr;
        if (k[6]) begin
            lyr = 3'd6;
        end else if (k[5]) begin
            lyr = 3'd5;
        end else if (k[4]) begin
            lyr = 3'd4;
        end else if (k[3]) begin
            lyr = 3'd3;
        end else if (k[2]) begin
            lyr = 3'd2;
        end else if (k[1]) begin
            lyr = 3'd1;
        end else begin
            lyr = 3'd0;
        end
        return lyr;
    endfunction

    // Number of butterflies sharing one zeta in a given layer.
    function automatic logic [7:0] zeta_len(input logic [2:0] lyr);
        return 8'd128 >> lyr;
    endfunction

endpackage

// File: rtl/zeta_repeat_cnt.sv
// Per-zeta repeat down-counter: loads len(k) and layer(k), counts consumed beats.
module zeta_repeat_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic [6:0] k_in,
    input  logic       dec,
    output logic [2:0] layer_o,
    output logic       last_o,
    output logic       last_nxt_o
);
    import zeta_pkg::*;

    logic [7:0] cnt_q, cnt_d;
    logic [2:0] layer_q, layer_d;

    // Next count: clear beats load, load beats decrement, otherwise hold.
    always_comb begin
        cnt_d   = cnt_q;
        layer_d = layer_q;
        if (clr) begin
            cnt_d   = 8'd0;
            layer_d = 3'd0;
        end else if (load) begin
            layer_d = zeta_layer(k_in);
            cnt_d   = zeta_len(layer_d);
        end else if (dec && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and layer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 8'd0;
            layer_q <= 3'd0;
        end else begin
            cnt_q   <= cnt_d;
            layer_q <= layer_d;
        end
    end

    assign layer_o    = layer_q;
    assign last_o     = (cnt_q == 8'd1);
    assign last_nxt_o = (cnt_d == 8'd1);

endmodule

// File: rtl/zeta_stream_reader.sv
// Streams twiddle factors from the registered-read zeta ROM to the butterfly
// datapath, repeating each zeta per butterfly and prefetching one zeta ahead.
module zeta_stream_reader #(
    parameter int WIDTH_ADDR = 7,
    parameter int DATA_W     = 32,
    parameter int ZETA_W     = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  abort,
    output logic                  busy,
    output logic                  rom_me,
    output logic                  rom_oe,
    output logic [WIDTH_ADDR-1:0] rom_addr,
    input  logic [DATA_W-1:0]     rom_q,
    output logic                  z_valid,
    input  logic                  z_ready,
    output logic [ZETA_W-1:0]     z_data,
    output logic [2:0]            z_layer,
    output logic                  z_last
);
    import zeta_pkg::*;

    localparam logic [WIDTH_ADDR-1:0] K_FIRST = {{(WIDTH_ADDR-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_ADDR-1:0] K_LAST  = {WIDTH_ADDR{1'b1}};

    // Next zeta index in walk order.
    function automatic logic [WIDTH_ADDR-1:0] step_k(input logic [WIDTH_ADDR-1:0] k,
                                                     input logic m);
        return (m == MODE_INTT) ? (k - K_FIRST) : (k + K_FIRST);
    endfunction

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic                  busy_q, busy_d;
    logic                  rom_me_q, rom_me_d;
    logic                  rom_oe_q, rom_oe_d;
    logic [WIDTH_ADDR-1:0] rom_addr_q, rom_addr_d;
    logic                  rd_pend_q, rd_pend_d;   // ROM data lands this cycle
    logic                  rd_done_q, rd_done_d;   // final zeta already requested
    logic [WIDTH_ADDR-1:0] k_rd_q, k_rd_d;         // next index to request
    logic [WIDTH_ADDR-1:0] cur_k_q, cur_k_d;
    logic                  cur_valid_q, cur_valid_d;
    logic [ZETA_W-1:0]     cur_data_q, cur_data_d;
    logic                  nxt_valid_q, nxt_valid_d;
    logic [ZETA_W-1:0]     nxt_data_q, nxt_data_d;
    logic                  z_valid_q, z_valid_d;
    logic                  z_last_q, z_last_d;

    logic                  rep_clr_s, rep_load_s, rep_dec_s;
    logic [WIDTH_ADDR-1:0] rep_k_s;
    logic [2:0]            rep_layer_s;
    logic                  rep_last_s, rep_last_nxt_s;
    logic                  fire_s, fill_load_s, need_cur_s;
    logic [WIDTH_ADDR-1:0] k_final_s;
    logic [ZETA_W-1:0]     rom_zeta_s;
    logic                  rom_q_unused_s;

    assign rom_zeta_s     = rom_q[ZETA_W-1:0];
    assign rom_q_unused_s = ^rom_q[DATA_W-1:ZETA_W];
    assign fire_s         = z_valid_q & z_ready;
    assign k_final_s      = (mode_q == MODE_INTT) ? K_FIRST : K_LAST;

    zeta_repeat_cnt u_rep (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (rep_clr_s),
        .load       (rep_load_s),
        .k_in       (rep_k_s),
        .dec        (rep_dec_s),
        .layer_o    (rep_layer_s),
        .last_o     (rep_last_s),
        .last_nxt_o (rep_last_nxt_s)
    );

    // FSM, cur/nxt staging and single-outstanding ROM read scheduling.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        rom_me_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rd_pend_d   = rom_me_q;
        rd_done_d   = rd_done_q;
        k_rd_d      = k_rd_q;
        cur_k_d     = cur_k_q;
        cur_valid_d = cur_valid_q;
        cur_data_d  = cur_data_q;
        nxt_valid_d = nxt_valid_q;
        nxt_data_d  = nxt_data_q;
        rep_clr_s   = 1'b0;
        rep_load_s  = 1'b0;
        rep_dec_s   = 1'b0;
        rep_k_s     = cur_k_q;
        fill_load_s = 1'b0;
        need_cur_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rd_pend_d = 1'b0;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d    = ST_FILL;
                    mode_d     = mode;
                    rom_me_d   = 1'b1;
                    rom_addr_d = (mode == MODE_INTT) ? K_LAST : K_FIRST;
                    cur_k_d    = (mode == MODE_INTT) ? K_LAST : K_FIRST;
                    k_rd_d     = step_k((mode == MODE_INTT) ? K_LAST : K_FIRST, mode);
                    rd_done_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    rd_pend_d   = 1'b0;
                    cur_valid_d = 1'b0;
                    nxt_valid_d = 1'b0;
                    cur_data_d  = {ZETA_W{1'b0}};
                    rep_clr_s   = 1'b1;
                end else if (rd_pend_q) begin
                    state_d     = ST_STREAM;
                    cur_data_d  = rom_zeta_s;
                    cur_valid_d = 1'b1;
                    rep_load_s  = 1'b1;
                    rep_k_s     = cur_k_q;
                    fill_load_s = 1'b1;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_STREAM: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    rd_pend_d   = 1'b0;
                    cur_valid_d = 1'b0;
                    nxt_valid_d = 1'b0;
                    cur_data_d  = {ZETA_W{1'b0}};
                    rep_clr_s   = 1'b1;
                end else if (fire_s && z_last_q) begin
                    state_d     = ST_DONE;
                    cur_valid_d = 1'b0;
                    nxt_valid_d = 1'b0;
                    rep_clr_s   = 1'b1;
                end else begin
                    need_cur_s = !cur_valid_q || (fire_s && rep_last_s);
                    if (need_cur_s && (nxt_valid_q || rd_pend_q)) begin
                        // Next zeta comes from the prefetch slot, or straight off the ROM.
                        cur_data_d  = nxt_valid_q ? nxt_data_q : rom_zeta_s;
                        cur_valid_d = 1'b1;
                        cur_k_d     = step_k(cur_k_q, mode_q);
                        rep_load_s  = 1'b1;
                        rep_k_s     = step_k(cur_k_q, mode_q);
                        nxt_valid_d = nxt_valid_q && rd_pend_q;
                        nxt_data_d  = (nxt_valid_q && rd_pend_q) ? rom_zeta_s : nxt_data_q;
                    end else if (need_cur_s) begin
                        cur_valid_d = 1'b0;
                    end else begin
                        if (rd_pend_q) begin
                            nxt_valid_d = 1'b1;
                            nxt_data_d  = rom_zeta_s;
                        end else begin
                            nxt_valid_d = nxt_valid_q;
                        end
                        rep_dec_s = fire_s;
                    end
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                rd_pend_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Prefetch: one read in flight at most, only into an empty slot, never under backpressure.
        if ((state_d == ST_STREAM) && !rd_done_q && !rom_me_q && !nxt_valid_d &&
            (fill_load_s || z_ready || !cur_valid_d)) begin
            rom_me_d   = 1'b1;
            rom_addr_d = k_rd_q;
            k_rd_d     = step_k(k_rd_q, mode_q);
            rd_done_d  = (k_rd_q == k_final_s);
        end else begin
            rom_me_d = rom_me_d;
        end
    end

    // Next values of the registered handshake and status outputs.
    always_comb begin
        busy_d    = (state_d == ST_FILL) || (state_d == ST_STREAM);
        rom_oe_d  = (state_d != ST_IDLE);
        z_valid_d = (state_d == ST_STREAM) && cur_valid_d;
        z_last_d  = z_valid_d && (cur_k_d == k_final_s) && rep_last_nxt_s;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_NTT;
            busy_q      <= 1'b0;
            rom_me_q    <= 1'b0;
            rom_oe_q    <= 1'b0;
            rom_addr_q  <= {WIDTH_ADDR{1'b0}};
            rd_pend_q   <= 1'b0;
            rd_done_q   <= 1'b0;
            k_rd_q      <= {WIDTH_ADDR{1'b0}};
            cur_k_q     <= {WIDTH_ADDR{1'b0}};
            cur_valid_q <= 1'b0;
            cur_data_q  <= {ZETA_W{1'b0}};
            nxt_valid_q <= 1'b0;
            nxt_data_q  <= {ZETA_W{1'b0}};
            z_valid_q   <= 1'b0;
            z_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            rom_me_q    <= rom_me_d;
            rom_oe_q    <= rom_oe_d;
            rom_addr_q  <= rom_addr_d;
            rd_pend_q   <= rd_pend_d;
            rd_done_q   <= rd_done_d;
            k_rd_q      <= k_rd_d;
            cur_k_q     <= cur_k_d;
            cur_valid_q <= cur_valid_d;
            cur_data_q  <= cur_data_d;
            nxt_valid_q <= nxt_valid_d;
            nxt_data_q  <= nxt_data_d;
            z_valid_q   <= z_valid_d;
            z_last_q    <= z_last_d;
        end
    end

    assign busy     = busy_q;
    assign rom_me   = rom_me_q;
    assign rom_oe   = rom_oe_q;
    assign rom_addr = rom_addr_q;
    assign z_valid  = z_valid_q;
    assign z_data   = cur_data_q;
    assign z_layer  = rep_layer_s;
    assign z_last   = z_last_q;

endmodule
